// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, ALUOp codes,
// datapath mux selects and the controller state enum.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_IFUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SUB    = 2'b11;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V main control FSM with a bounded wait on the shared memory port.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE   | opcode dispatch, branch/jump target -> ALUOut
// MEMADR   | rs1 + imm -> ALUOut for load/store
// MEMREAD  | data read at ALUOut
// MEMWB    | memory data -> rd, retire
// MEMWRITE | data write at ALUOut, retire on mem_ready
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | ALUOut -> rd, retire
// BRANCH   | rs1 - rs2, take branch on zero, retire
// JAL      | target -> PC, old PC + 4 -> ALUOut
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    state_t          state, state_next;
    logic [TO_W-1:0] wait_cnt;
    logic            wait_inc;
    logic            expired;

    assign expired = (wait_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_inc ? wait_cnt + TO_W'(1) : '0;
        end
    end

    always_comb begin
        state_next    = state;
        wait_inc      = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = ADR_PC;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_IFUNCT;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;

        case (state)
            S_FETCH: begin
                adr_src    = ADR_PC;
                mem_read   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALURES;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (expired) begin
                    mem_read    = 1'b0;
                    mem_timeout = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src  = ADR_ALUOUT;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (expired) begin
                    mem_read    = 1'b0;
                    mem_timeout = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = ADR_ALUOUT;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (expired) begin
                    mem_write   = 1'b0;
                    mem_timeout = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_RFUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_IFUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase

        // The reset state is FETCH, whose decode would otherwise strobe memory during reset.
        if (!rst_n) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            adr_src       = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            result_src    = 2'b00;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
            mem_timeout   = 1'b0;
        end
    end

endmodule
